muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It takes the same ID/EX operands as the ALU and runs in parallel with it, selected when the decoded instruction is an M-extension op. Its result feeds the EX/MEM register through the EX result mux. Busy drives the hazard unit, which stalls IF/ID/EX while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
OPCODE_LENGTH, 3, width of Funct3 (RV32M funct3 encoding)

Ports:
clk  input  1  pipeline clock, rising-edge
reset  input  1  asynchronous, active-high reset
Start  input  1  request; sampled on a clk edge while state is IDLE or DONE
Flush  input  1  synchronous abort from branch/exception flush
Funct3  input  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  DATA_WIDTH  rs1 value (multiplicand / dividend)
SrcB  input  DATA_WIDTH  rs2 value (multiplier / divisor)
Busy  output  1  high while state is CALC
Done  output  1  one-cycle pulse; Result valid in that cycle
Result  output  DATA_WIDTH  registered result; held until the next accepted Start

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high. Reset forces state=IDLE, Busy=0, Done=0, Result=0 and clears all internal registers. Reset mid-operation discards the operation; no Done is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE + Start: latch Funct3 and operand magnitudes, sign flags and iteration counter=0; go to CALC.
  - Exception: special divide cases (below) go straight to DONE.
- CALC: one radix-2 iteration per cycle. After DATA_WIDTH iterations (counter wraps at DATA_WIDTH-1), apply sign correction, load Result, go to DONE.
- DONE: Done=1 for exactly one cycle.
  - Start in this cycle is accepted (back-to-back, same as IDLE + Start).
  - Otherwise go to IDLE.
- Start while Busy=1 is ignored.
- Latency:
  - Normal path: Start sampled at edge E0, iterations on edges E1..E32, Done high in the cycle after E32, i.e. 33 cycles after the Start cycle.
  - Special cases: Done high in the cycle after E0.
- Multiply:
  - Convert operands to unsigned magnitudes. SrcA is signed for MULH and MULHSU; SrcB is signed for MULH only.
  - Shift-add into a 2*DATA_WIDTH product.
  - Negate the product if exactly one operand was treated as negative.
  - MUL returns the low DATA_WIDTH bits; MULH, MULHSU and MULHU return the high DATA_WIDTH bits.
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Special cases (no iteration):
  - Divisor=0: DIV/DIVU return all-ones; REM/REMU return SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Flush:
  - Flush=1 at an edge forces IDLE and Busy=0.
  - A Done pending in that cycle is suppressed.
  - Result keeps its previous value.
  - Flush overrides a simultaneous Start.
- Operand latching: SrcA, SrcB and Funct3 may change after the Start edge; only the latched copies are used.

Decomposition:
- Shared package (muldiv_pkg):
  - funct3 enum: MUL..REMU.
  - state enum: IDLE/CALC/DONE.
  - localparam ITER_W = $clog2(DATA_WIDTH).
  - helper function for two's-complement negate of a parametrised width.
- Sub-modules: none required. The shift-add and restoring-subtract steps share one DATA_WIDTH+1 adder inside the module. No multiplier primitives.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD (-3) -> Done 33 cycles after Start; Result=0xFFFFFFEB; Busy high for 32 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF. REM 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. Each with Done one cycle after Start and Busy never high.
- Back-to-back: Start during Done cycle with new op -> second Done 33 cycles later. Start pulsed while Busy -> ignored, first result unaffected.
- Flush at iteration 10 -> IDLE next cycle, no Done, Result unchanged. Then assert reset mid-CALC -> Busy=0, Done=0, Result=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN   = 32;
  localparam int ITER_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Two's-complement negate at double-word width; narrower users truncate.
  function automatic logic [2*XLEN-1:0] twos_neg(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// magnitudes, one radix-2 step per cycle through a single shared adder.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic                     Flush,
  input  logic [OPCODE_LENGTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int CNT_W = (DATA_WIDTH == XLEN) ? ITER_W : $clog2(DATA_WIDTH);
  localparam int PW    = 2 * XLEN;

  state_e                state, state_nx;
  funct3_e               op_q, op_in;
  logic [DATA_WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  neg_q, neg_a_q;

  logic                  a_sgn, b_sgn, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic                  div_zero, div_ovf, special, accept, last_iter;
  logic [DATA_WIDTH-1:0] special_res;

  logic [DATA_WIDTH:0]   add_x, add_y, add_sum;
  logic                  add_cin, borrow;
  logic [DATA_WIDTH-1:0] hi_it, lo_it;
  logic [PW-1:0]         prod_neg_full;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0] quot_fix, rem_fix, res_calc;

  // Operand decode at the accepting edge
  always_comb begin
    op_in    = funct3_e'(Funct3);
    a_sgn    = (op_in == F3_MULH) || (op_in == F3_MULHSU) ||
               (op_in == F3_DIV)  || (op_in == F3_REM);
    b_sgn    = (op_in == F3_MULH) || (op_in == F3_DIV) || (op_in == F3_REM);
    a_neg    = a_sgn && SrcA[DATA_WIDTH-1];
    b_neg    = b_sgn && SrcB[DATA_WIDTH-1];
    mag_a    = a_neg ? (~SrcA + 1'b1) : SrcA;
    mag_b    = b_neg ? (~SrcB + 1'b1) : SrcB;
    div_zero = op_in[2] && (SrcB == '0);
    div_ovf  = ((op_in == F3_DIV) || (op_in == F3_REM)) &&
               (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (SrcB == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op_in[1] ? SrcA : '1;
    else          special_res = op_in[1] ? '0 : SrcA;
    accept    = Start && !Flush && ((state == IDLE) || (state == DONE));
    last_iter = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end

  // Shared adder: accumulate for multiply, trial-subtract for divide
  always_comb begin
    if (op_q[2]) begin
      add_x   = {hi_q, lo_q[DATA_WIDTH-1]};
      add_y   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, hi_q};
      add_y   = lo_q[0] ? {1'b0, b_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + {{DATA_WIDTH{1'b0}}, add_cin};
    borrow  = add_sum[DATA_WIDTH];
    if (op_q[2]) begin
      hi_it = borrow ? add_x[DATA_WIDTH-1:0] : add_sum[DATA_WIDTH-1:0];
      lo_it = {lo_q[DATA_WIDTH-2:0], ~borrow};
    end else begin
      hi_it = add_sum[DATA_WIDTH:1];
      lo_it = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final iteration's outputs
  always_comb begin
    prod_neg_full = twos_neg(PW'({hi_it, lo_it}));
    prod_fix      = neg_q ? prod_neg_full[2*DATA_WIDTH-1:0] : {hi_it, lo_it};
    quot_fix      = neg_q ? (~lo_it + 1'b1) : lo_it;
    rem_fix       = neg_a_q ? (~hi_it + 1'b1) : hi_it;
    case (op_q)
      F3_MUL:                       res_calc = prod_fix[DATA_WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_calc = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      F3_DIV, F3_DIVU:              res_calc = quot_fix;
      default:                      res_calc = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)              state_nx = special ? DONE : CALC;
        else if (state == DONE)  state_nx = IDLE;
      end
      CALC:    if (last_iter) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (Flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= F3_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_a_q <= 1'b0;
      Result  <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      hi_q    <= '0;
      lo_q    <= mag_a;
      b_q     <= mag_b;
      cnt_q   <= '0;
      neg_q   <= a_neg ^ b_neg;
      neg_a_q <= a_neg;
      if (special) Result <= special_res;
    end else if ((state == CALC) && !Flush) begin
      hi_q  <= hi_it;
      lo_q  <= lo_it;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) Result <= res_calc;
    end
  end

  assign Busy = (state == CALC);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, back-to-back, flush, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Busy, Done;
  logic [31:0] Result;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; Start is sampled at the next posedge, then operands scrambled.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  // lat = cycles since the Start cycle at the current negedge.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                           input int exp_busy, input logic [31:0] exp_res);
    int lat = lat0;
    int busy_n = 0;
    while (!Done && lat < 60) begin
      if (Busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
    chk({tag, " result"}, Result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic special);
    @(negedge clk);
    issue(f3, a, b);
    if (special) wait_done(tag, 1, 1, 0, exp_res);
    else         wait_done(tag, 1, 33, 32, exp_res);
    @(negedge clk);
    chk({tag, " done one cycle"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int saw_done;
    #12;
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    chk("reset result", Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhu max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("rem 100/0", REM, 32'd100, 32'd0, 32'd100, 1'b1);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Back-to-back: second Start lands in the Done cycle of the first
    @(negedge clk);
    issue(MUL, 32'd5, 32'd6);
    wait_done("b2b first", 1, 33, 32, 32'd30);
    issue(DIVU, 32'd100, 32'd7);
    wait_done("b2b second", 1, 33, 32, 32'd14);
    @(negedge clk);
    chk("b2b done drop", 32'(Done), 32'd0);

    // Start pulsed while busy must be ignored
    @(negedge clk);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    Start = 1'b1; Funct3 = DIVU; SrcA = 32'd9; SrcB = 32'd0;
    @(negedge clk);
    Start = 1'b0;
    wait_done("start while busy", 6, 33, 27, 32'hFFFF_FFFE);
    @(negedge clk);

    // Flush sampled at iteration edge 10
    @(negedge clk);
    issue(MUL, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("flush busy", 32'(Busy), 32'd0);
    chk("flush done", 32'(Done), 32'd0);
    chk("flush result held", Result, 32'hFFFF_FFFE);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) saw_done = 1;
    end
    chk("flush no done", 32'(saw_done), 32'd0);

    // Flush wins over a simultaneous Start of a one-cycle special op
    Start = 1'b1; Flush = 1'b1; Funct3 = DIVU; SrcA = 32'd5; SrcB = 32'd0;
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    chk("flush+start done", 32'(Done), 32'd0);
    chk("flush+start result", Result, 32'hFFFF_FFFE);

    // Asynchronous reset mid-calculation
    issue(MUL, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 32'(Busy), 32'd0);
    chk("async reset done", 32'(Done), 32'd0);
    chk("async reset result", Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) saw_done = 1;
    end
    chk("reset no done", 32'(saw_done), 32'd0);

    run_op("post-reset remu", REMU, 32'd100, 32'd7, 32'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
